alu_reg_sequencer: RTL and testbench
====================================

Name: alu_reg_sequencer

Overview:
- Command sequencer that sits directly upstream of the 4-bit `alu` and `register` blocks and drives both.
- Accepts one command at a time over a valid/ready handshake.
- Translates each command into ALU operand/opcode drive and single-cycle register control pulses.
- Returns the resulting register contents over a valid/ready response channel, and counts completed commands.

Parameters:
- W, 4, datapath width; equals the alu/register width.
- CNT_W, 8, width of the completed-command counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  command code (see Behaviour)
- cmd_oc  in  3  ALU opcode, used by the ALU command only
- cmd_imm  in  W  immediate; bit 0 is also the shift fill bit
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  W  register value after the command
- rsp_err  out  1  illegal cmd_op
- alu_oc  out  3  to alu.oc
- alu_a  out  W  to alu.a
- alu_b  out  W  to alu.b
- alu_f  in  W  from alu.f (combinational)
- reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl  out  1 each  to register controls
- reg_ir, reg_il  out  1 each  shift fill bits
- reg_in  out  W  to register.in
- reg_out  in  W  from register.out
- cmd_count  out  CNT_W  completed-command counter

Behaviour:
- Reset:
  - Async on rst_n low: state=IDLE, cmd_count=0, latched op/oc/imm/result=0.
  - All reg_* and alu_* outputs are 0; rsp_valid=0, rsp_data=0, rsp_err=0.
  - Reset mid-command aborts the command; no further register pulses are issued.
- Command codes:
  - 0 NOP
  - 1 LOAD (reg_in=imm, reg_ld)
  - 2 ALU
  - 3 INC
  - 4 DEC
  - 5 SHR (reg_sr, reg_ir=imm[0])
  - 6 SHL (reg_sl, reg_il=imm[0])
  - 7 CLR (reg_cl)
  - 8..15 illegal
- States:
  - IDLE: cmd_ready=1. If cmd_valid, latch op/oc/imm and go to EXEC. Commands are accepted only in IDLE.
  - EXEC:
    - ALU: alu_oc=oc, alu_a=reg_out, alu_b=imm. Capture alu_f into the result register at the end of the cycle, then go to WB.
    - LOAD/INC/DEC/SHR/SHL/CLR: assert exactly that one control for exactly this one cycle, then go to RESP.
    - NOP and illegal: no pulse, go to RESP.
  - WB (ALU only): reg_in=result, reg_ld=1 for one cycle, then go to RESP.
  - RESP: rsp_valid=1, rsp_data=reg_out, rsp_err=1 only for illegal op. Hold until rsp_ready. On the rsp_valid&rsp_ready edge: cmd_count+=1 (wraps at 2^CNT_W-1 to 0), then go to IDLE.
- Output drive outside the above:
  - At most one of cl/ld/inc/dec/sr/sl is high in any cycle.
  - Outside its pulse cycle every reg_* output is 0, and alu_* are 0 outside EXEC of an ALU command.
  - In RESP all register controls are 0, so rsp_data is stable while stalled.
- Latency, counting the accept cycle as 0:
  - ALU: rsp_valid in cycle 3.
  - All other ops: rsp_valid in cycle 2.
  - A new command is accepted no earlier than the cycle after the response handshake; no back-to-back overlap.
- Counter scope: cmd_count counts illegal and NOP commands too.
- Arithmetic: INC/DEC wrap modulo 2^W inside the register. The sequencer never computes data itself; only ALU results pass through its result register.
- Timing: rsp_ready may be high before RESP; a handshake occurs only in RESP.

Test Plan:
- Reset with cmd_valid=1, then release → no register pulse during reset; first accept on the first clk edge after release; cmd_count=0; all reg_*/alu_* are 0 during reset.
- LOAD imm=4'b1011, then INC, rsp_ready=1 → responses 4'b1011, then 4'b1100; rsp_valid in cycle 2 of each command; cmd_count=2.
- LOAD 4'hF, INC → rsp_data=4'h0 (wrap). DEC → 4'hF. SHR imm[0]=0 → 4'b0111. SHL imm[0]=1 → 4'b1111.
- ALU oc=3'b010, imm=4'h3, with the register holding 4'h5 and the bench model returning alu_f=4'hA → alu_oc=010, alu_a=5, alu_b=3 in cycle 1; reg_ld with reg_in=4'hA in cycle 2; rsp_data=4'hA in cycle 3.
- Hold rsp_ready=0 for 5 cycles after CLR → rsp_valid and rsp_data=0 held stable, cmd_ready=0, no controls asserted; second cmd_valid is ignored until after the handshake.
- cmd_op=4'hC → rsp_err=1, register unchanged, cmd_count increments; pulse rst_n low during WB of an ALU command → reg_ld drops immediately, state=IDLE, no response.

Source files
------------

// File: rtl/alu_reg_sequencer.sv
// Command sequencer driving a W-bit ALU and register: turns one handshaked command
// into operand drive and single-cycle register pulses, then returns the register value.
module alu_reg_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [2:0]       cmd_oc,
  input  logic [W-1:0]     cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_err,
  output logic [2:0]       alu_oc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_f,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_sl,
  output logic             reg_ir,
  output logic             reg_il,
  output logic [W-1:0]     reg_in,
  input  logic [W-1:0]     reg_out,
  output logic [CNT_W-1:0] cmd_count
);

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ALU  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd7;

  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       oc_q, oc_d;
  logic [W-1:0]     imm_q, imm_d;
  logic [W-1:0]     result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      oc_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      oc_q     <= oc_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    oc_d      = oc_q;
    imm_d     = imm_q;
    result_d  = result_q;
    count_d   = count_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    alu_oc    = '0;
    alu_a     = '0;
    alu_b     = '0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_sl    = 1'b0;
    reg_ir    = 1'b0;
    reg_il    = 1'b0;
    reg_in    = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          oc_d    = cmd_oc;
          imm_d   = cmd_imm;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        case (op_q)
          OP_LOAD: begin
            reg_ld = 1'b1;
            reg_in = imm_q;
          end
          OP_ALU: begin
            alu_oc   = oc_q;
            alu_a    = reg_out;
            alu_b    = imm_q;
            result_d = alu_f;
            state_d  = WB;
          end
          OP_INC: reg_inc = 1'b1;
          OP_DEC: reg_dec = 1'b1;
          OP_SHR: begin
            reg_sr = 1'b1;
            reg_ir = imm_q[0];
          end
          OP_SHL: begin
            reg_sl = 1'b1;
            reg_il = imm_q[0];
          end
          OP_CLR: reg_cl = 1'b1;
          default: ;
        endcase
      end
      WB: begin
        reg_in  = result_q;
        reg_ld  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // Controls stay idle here, so reg_out and hence rsp_data hold during a stall.
        rsp_valid = 1'b1;
        rsp_data  = reg_out;
        rsp_err   = op_q[3];
        if (rsp_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_count = count_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with stand-in ALU and register models
// and a response scoreboard.
module tb_alu_reg_sequencer;
  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [2:0]       cmd_oc;
  logic [W-1:0]     cmd_imm;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]     rsp_data;
  logic [2:0]       alu_oc;
  logic [W-1:0]     alu_a, alu_b, alu_f;
  logic             reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
  logic [W-1:0]     reg_in, reg_out;
  logic [CNT_W-1:0] cmd_count;
  logic [7:0]       ctl;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } sb_t;

  sb_t          sb_q[$];
  logic [W-1:0] exp_reg;
  int           exp_count;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model_q;

  always #5 clk = ~clk;

  alu_reg_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_oc(cmd_oc),
    .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
    .reg_in(reg_in), .reg_out(reg_out), .cmd_count(cmd_count)
  );

  function automatic logic [W-1:0] alu_fn(input logic [2:0] oc, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (oc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << 1;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  assign alu_f   = alu_fn(alu_oc, alu_a, alu_b);
  assign reg_out = model_q;
  assign ctl     = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il};

  // Register stand-in; it has no reset so an aborted command leaves it untouched.
  always_ff @(posedge clk) begin
    if (reg_cl)       model_q <= '0;
    else if (reg_ld)  model_q <= reg_in;
    else if (reg_inc) model_q <= model_q + 1'b1;
    else if (reg_dec) model_q <= model_q - 1'b1;
    else if (reg_sr)  model_q <= {reg_ir, model_q[W-1:1]};
    else if (reg_sl)  model_q <= {model_q[W-2:0], reg_il};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check();
    sb_t got;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(got.data));
      chk("rsp_err", 32'(rsp_err), 32'(got.err));
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [2:0] oc, input logic [W-1:0] imm,
                         input int stall);
    logic [W-1:0] old_v, new_v, in_e;
    logic [7:0]   ctl_e;
    int           lat_e, cyc;
    old_v = exp_reg; new_v = old_v; ctl_e = '0; in_e = '0; lat_e = 2;
    case (op)
      4'd1: begin new_v = imm; ctl_e = 8'b0100_0000; in_e = imm; end
      4'd2: begin new_v = alu_fn(oc, old_v, imm); lat_e = 3; end
      4'd3: begin new_v = old_v + 1'b1; ctl_e = 8'b0010_0000; end
      4'd4: begin new_v = old_v - 1'b1; ctl_e = 8'b0001_0000; end
      4'd5: begin new_v = {imm[0], old_v[W-1:1]}; ctl_e = {6'b000010, imm[0], 1'b0}; end
      4'd6: begin new_v = {old_v[W-2:0], imm[0]}; ctl_e = {6'b000001, 1'b0, imm[0]}; end
      4'd7: begin new_v = '0; ctl_e = 8'b1000_0000; end
      default: ;
    endcase
    exp_reg = new_v;
    sb_q.push_back('{data: new_v, err: op[3]});

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_oc = oc; cmd_imm = imm; rsp_ready = (stall == 0);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cyc = 1;
    chk("ctl_c1", 32'(ctl), 32'(ctl_e));
    chk("reg_in_c1", 32'(reg_in), 32'(in_e));
    chk("alu_oc_c1", 32'(alu_oc), (op == 4'd2) ? 32'(oc) : 32'd0);
    chk("alu_a_c1", 32'(alu_a), (op == 4'd2) ? 32'(old_v) : 32'd0);
    chk("alu_b_c1", 32'(alu_b), (op == 4'd2) ? 32'(imm) : 32'd0);
    if (op == 4'd2) begin
      @(negedge clk);
      cyc = 2;
      chk("ctl_wb", 32'(ctl), 32'h40);
      chk("reg_in_wb", 32'(reg_in), 32'(new_v));
      chk("alu_a_wb", 32'(alu_a), 32'd0);
    end
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 12);
    chk("latency", 32'(cyc), 32'(lat_e));
    chk("ctl_resp", 32'(ctl), 32'd0);
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_imm = 4'h9;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(new_v));
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      chk("stall_ctl", 32'(ctl), 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    pop_and_check();
    chk("count_pre", 32'(cmd_count), 32'(exp_count));
    @(negedge clk);
    exp_count++;
    chk("count_post", 32'(cmd_count), 32'(exp_count));
    chk("rsp_valid_post", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    model_q = '0;
    exp_reg = '0; exp_count = 0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_oc = '0; cmd_imm = 4'b1011;

    // Reset held with a command offered: nothing may move.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", 32'(ctl), 32'd0);
      chk("rst_alu", 32'({alu_oc, alu_a, alu_b}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
      chk("rst_count", 32'(cmd_count), 32'd0);
      chk("rst_reg", 32'(reg_out), 32'd0);
    end
    rst_n = 1'b1;
    exp_reg = 4'b1011;
    sb_q.push_back('{data: 4'b1011, err: 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("first_accept_ld", 32'(ctl), 32'h40);
    chk("first_accept_in", 32'(reg_in), 32'hB);
    @(negedge clk);
    chk("first_rsp_valid", 32'(rsp_valid), 32'd1);
    pop_and_check();
    @(negedge clk);
    exp_count = 1;
    chk("first_count", 32'(cmd_count), 32'd1);

    run_cmd(4'd3, 3'd0, 4'h0, 0);      // INC -> 1100
    run_cmd(4'd1, 3'd0, 4'hF, 0);      // LOAD F
    run_cmd(4'd3, 3'd0, 4'h0, 0);      // INC wraps to 0
    run_cmd(4'd4, 3'd0, 4'h0, 0);      // DEC wraps to F
    run_cmd(4'd5, 3'd0, 4'h0, 0);      // SHR fill 0 -> 0111
    run_cmd(4'd6, 3'd0, 4'h1, 0);      // SHL fill 1 -> 1111
    run_cmd(4'd1, 3'd0, 4'h5, 0);      // LOAD 5
    run_cmd(4'd2, 3'b010, 4'h3, 0);    // ALU -> A
    chk("alu_result_A", 32'(reg_out), 32'hA);
    run_cmd(4'd7, 3'd0, 4'h0, 5);      // CLR, consumer stalls 5 cycles
    run_cmd(4'hC, 3'd0, 4'h0, 0);      // illegal
    run_cmd(4'd0, 3'd0, 4'h0, 0);      // NOP
    run_cmd(4'd1, 3'd0, 4'h6, 0);      // LOAD 6

    // Reset pulsed during WB of an ALU command must abort the write.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_oc = 3'd0; cmd_imm = 4'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wb_ld_before_rst", 32'(reg_ld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("wb_ld_after_rst", 32'(ctl), 32'd0);
    chk("wb_rst_count", 32'(cmd_count), 32'd0);
    chk("wb_rst_ready", 32'(cmd_ready), 32'd1);
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_no_ctl", 32'(ctl), 32'd0);
    end
    run_cmd(4'd0, 3'd0, 4'h0, 0);      // NOP reads back untouched 6

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
